// File: rtl/addsub_seq.sv
// Issue/capture stage in front of a ripple add/sub unit: registers A/B/SUB, waits SETTLE cycles, captures ans/cout/V.
// Optional sticky overflow flag is built only when ADDSUB_SEQ_STICKY_OVF_EN is defined.
module addsub_seq #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             SUB,
  input  logic [WIDTH-1:0] ans,
  input  logic             cout,
  input  logic             V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ans,
  output logic             out_cout,
  output logic             out_V,
  output logic             out_z,
  output logic             out_n,
  input  logic             clr_sticky,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic             accept;
  logic             capture;

  assign accept  = (state == ST_IDLE) && in_valid;
  assign capture = (state == ST_WAIT) && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_WAIT;
      ST_WAIT: if (capture)   state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags depend on state only; rst masks them while reset is held.
  always_comb begin
    in_ready  = !rst && (state == ST_IDLE);
    out_valid = !rst && (state == ST_HOLD);
  end

  // Operand drive: changes only on accept so the adder inputs stay stable while it settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A   <= '0;
      B   <= '0;
      SUB <= 1'b0;
    end else if (accept) begin
      A   <= in_acc ? acc : in_a;
      B   <= in_b;
      SUB <= in_sub;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (accept)             cnt <= '0;
    else if (state == ST_WAIT)   cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ans  <= '0;
      out_cout <= 1'b0;
      out_V    <= 1'b0;
      out_z    <= 1'b0;
      out_n    <= 1'b0;
      acc      <= '0;
    end else if (capture) begin
      out_ans  <= ans;
      out_cout <= cout;
      out_V    <= V;
      out_z    <= (ans == '0);
      out_n    <= ans[WIDTH-1];
      acc      <= ans;
    end
  end

`ifdef ADDSUB_SEQ_STICKY_OVF_EN
  logic sticky_q;

  // A capture with V=1 takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sticky_q <= 1'b0;
    else if (capture && V)   sticky_q <= 1'b1;
    else if (clr_sticky)     sticky_q <= 1'b0;
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign ovf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed table, hand-written corner sequences and randomized ops vs a reference model.
module tb_addsub_seq;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_sub = 1'b0;
  logic             in_acc = 1'b0;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             V;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_ans;
  logic             out_cout;
  logic             out_V;
  logic             out_z;
  logic             out_n;
  logic             clr_sticky = 1'b0;
  logic             ovf_sticky;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_acc = '0;
  logic             model_sticky = 1'b0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .A(A), .B(B), .SUB(SUB),
    .ans(ans), .cout(cout), .V(V),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ans(out_ans), .out_cout(out_cout), .out_V(out_V), .out_z(out_z), .out_n(out_n),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  // Ripple adder stand-in: outputs are corrupted until SETTLE-1 falling edges after any operand change,
  // so only a capture at the correct edge sees the true sum.
  logic [WIDTH:0]       sum_full;
  logic [WIDTH-1:0]     b_eff;
  logic                 v_raw;
  logic                 settled;
  logic [2*WIDTH:0]     prev_abs = '1;
  int                   age = 0;

  always_comb begin
    b_eff    = SUB ? ~B : B;
    sum_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, SUB};
    v_raw    = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != A[WIDTH-1]);
    settled  = (age >= SETTLE - 1);
  end

  assign ans  = settled ? sum_full[WIDTH-1:0] : (sum_full[WIDTH-1:0] ^ 32'hA5A5_5A5A);
  assign cout = settled ? sum_full[WIDTH] : ~sum_full[WIDTH];
  assign V    = settled ? v_raw : ~v_raw;

  always @(negedge clk) begin
    if ({A, B, SUB} != prev_abs) begin
      prev_abs <= {A, B, SUB};
      age      <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference from signed/unsigned integer rules.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 output logic [31:0] r, output logic c, output logic v);
    longint sa;
    longint sb;
    longint sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? (a - b) : (a + b);
    c  = sub ? (a >= b) : (({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF);
    sr = sub ? (sa - sb) : (sa + sb);
    v  = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic acc,
                        input int hold, input logic clr_cap, input logic early,
                        input logic [31:0] exp_a, input logic [31:0] exp_ans,
                        input logic exp_c, input logic exp_v, input logic exp_z, input logic exp_n);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_wait", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_acc = acc;
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub; in_acc = ~acc;
    if (early) out_ready = 1'b1;
    check("drive_A", A, exp_a);
    check("drive_B", B, b);
    check("drive_SUB", 32'(SUB), 32'(sub));
    check("wait_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < SETTLE + 20) begin
      clr_sticky = clr_cap && (n == SETTLE - 1);
      @(negedge clk);
      n++;
    end
    clr_sticky = 1'b0;
    check("latency", 32'(n), 32'(SETTLE));
    if (!out_valid) begin
      out_ready = 1'b0;
      return;
    end
`ifdef ADDSUB_SEQ_STICKY_OVF_EN
    model_sticky = (clr_cap ? 1'b0 : model_sticky) | exp_v;
`endif
    check("out_ans", out_ans, exp_ans);
    check("out_cout", 32'(out_cout), 32'(exp_c));
    check("out_V", 32'(out_V), 32'(exp_v));
    check("out_z", 32'(out_z), 32'(exp_z));
    check("out_n", 32'(out_n), 32'(exp_n));
    check("ovf_sticky", 32'(ovf_sticky), 32'(model_sticky));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = 32'(i) + 32'h100; in_b = 32'h55; in_sub = 1'b0; in_acc = 1'b0;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_ans", out_ans, exp_ans);
      check("bp_A", A, exp_a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_A_held", A, exp_a);
    model_acc = exp_ans;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        acc;
    int          hold;
    logic        clr;
    logic [31:0] exp_a;
    logic [31:0] exp_ans;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ea;
    logic [31:0] r;
    logic        rs;
    logic        racc;
    logic        rc;
    logic        rv;
    logic        early;
    logic        rclr;
    int          rhold;

    vecs[0] = '{32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0021, 32'h0000_0043, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 0, 1'b0, 32'h0000_0021, 32'h0000_0043, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0000_0043, 1'b1, 1'b1, 0, 1'b1, 32'h0000_0043, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};

    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_SUB", 32'(SUB), 32'd0);
    check("rst_out_ans", out_ans, 32'h0);
    check("rst_flags", 32'({out_cout, out_V, out_z, out_n, ovf_sticky}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Accumulator is 0 after reset.
    run_op(32'h1234_5678, 32'h0000_0005, 1'b0, 1'b1, 0, 1'b0, 1'b0,
           32'h0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].acc, vecs[i].hold, vecs[i].clr, 1'b0,
             vecs[i].exp_a, vecs[i].exp_ans, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);

    // Clear pulse while idle.
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky   = 1'b0;
    model_sticky = 1'b0;
    check("sticky_clr_idle", 32'(ovf_sticky), 32'd0);

    for (int i = 0; i < 30; i++) begin
      ra    = pick();
      rb    = pick();
      rs    = 1'($urandom_range(0, 1));
      racc  = ($urandom_range(0, 3) == 0);
      ea    = racc ? model_acc : ra;
      ref_op(ea, rb, rs, r, rc, rv);
      early = 1'($urandom_range(0, 1));
      rhold = early ? 0 : int'($urandom_range(0, 2));
      rclr  = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rs, racc, rhold, rclr, early, ea, r, rc, rv, (r == 32'h0), r[31]);
    end

    // Overflow to set the sticky flag, then reset in the middle of WAIT.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0,
           32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_a = 32'h0000_1234; in_b = 32'h0000_5678; in_sub = 1'b1; in_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_A", A, 32'h0);
    check("midrst_B", B, 32'h0);
    check("midrst_SUB", 32'(SUB), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_ans", out_ans, 32'h0);
    check("midrst_sticky", 32'(ovf_sticky), 32'd0);
    model_acc    = '0;
    model_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    run_op(32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b0,
           32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 0, 1'b0, 1'b0,
           32'h0000_0021, 32'h0000_0043, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
